cim_inst_queue: RTL

Instruction queue that sits directly upstream of rw_control. It accepts raw 32-bit CIM instruction words from the host/loader over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It issues each word to rw_control over a second valid/ready handshake, split into op/s1/s2/d1 fields (cim_field_struct layout). NOP words are dropped at entry; a synchronous flush and an issue counter are provided.

---
 rtl/cim_inst_queue_pkg.sv | 40 ++++
 rtl/cim_inst_queue_if.sv | 39 +++
 rtl/cim_inst_queue_fifo.sv | 60 ++++++
 rtl/cim_inst_queue.sv | 75 +++++++
 4 files changed

// File: rtl/cim_inst_queue_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cim_inst_queue_pkg : CIM instruction field layout and queue constants |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package cim_inst_queue_pkg;

    localparam int CIM_INST_WIDTH = 32;
    localparam int CIM_IQ_DEPTH   = 8;
    localparam int CIM_CNT_WIDTH  = 16;

    localparam int OP_WIDTH = 8;
    localparam int S1_WIDTH = 8;
    localparam int S2_WIDTH = 8;
    localparam int D1_WIDTH = 8;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 24;
    localparam int S1_MSB = 23;
    localparam int S1_LSB = 16;
    localparam int S2_MSB = 15;
    localparam int S2_LSB = 8;
    localparam int D1_MSB = 7;
    localparam int D1_LSB = 0;

    localparam logic [OP_WIDTH-1:0] OP_NOP = 8'h00;

    typedef struct packed {
        logic [OP_WIDTH-1:0] op;
        logic [S1_WIDTH-1:0] s1;
        logic [S2_WIDTH-1:0] s2;
        logic [D1_WIDTH-1:0] d1;
    } cim_field_struct;

    function automatic logic is_nop(input logic [CIM_INST_WIDTH-1:0] inst);
        return inst[OP_MSB:OP_LSB] == OP_NOP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cim_inst_queue_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cim_inst_queue_if : host push / rw_control issue handshake bundle     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface cim_inst_queue_if
    import cim_inst_queue_pkg::*;
#(
    parameter int INST_WIDTH = CIM_INST_WIDTH,
    parameter int DEPTH      = CIM_IQ_DEPTH,
    parameter int CNT_WIDTH  = CIM_CNT_WIDTH
);
    logic [INST_WIDTH-1:0]        host_inst_i;
    logic                         host_valid_i;
    logic                         host_ready_o;
    logic                         flush_i;
    logic                         issue_valid_o;
    logic                         issue_ready_i;
    logic [7:0]                   issue_op_o;
    logic [7:0]                   issue_s1_o;
    logic [7:0]                   issue_s2_o;
    logic [7:0]                   issue_d1_o;
    logic [$clog2(DEPTH+1)-1:0]   count_o;
    logic [CNT_WIDTH-1:0]         issued_cnt_o;

    // master: host/loader plus rw_control side; slave: the queue itself
    modport master (
        output host_inst_i, host_valid_i, flush_i, issue_ready_i,
        input  host_ready_o, issue_valid_o, issue_op_o, issue_s1_o,
               issue_s2_o, issue_d1_o, count_o, issued_cnt_o
    );

    modport slave (
        input  host_inst_i, host_valid_i, flush_i, issue_ready_i,
        output host_ready_o, issue_valid_o, issue_op_o, issue_s1_o,
               issue_s2_o, issue_d1_o, count_o, issued_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/cim_inst_queue_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cim_inst_fifo : generic synchronous FIFO with count-based full/empty  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module cim_inst_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (rd_en) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clear) r_mem[r_wr_ptr] <= wr_data;
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;
    assign full    = (r_count == CNT_W'(DEPTH));
    assign empty   = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/cim_inst_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cim_inst_queue : NOP-filtering instruction queue ahead of rw_control  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module cim_inst_queue
    import cim_inst_queue_pkg::*;
#(
    parameter int INST_WIDTH = CIM_INST_WIDTH,
    parameter int DEPTH      = CIM_IQ_DEPTH,
    parameter int CNT_WIDTH  = CIM_CNT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    cim_inst_queue_if.slave   bus
);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic                  w_full;
    logic                  w_empty;
    logic [INST_WIDTH-1:0] w_rd_data;
    logic [CNT_W-1:0]      w_count;
    logic                  w_host_ready;
    logic                  w_issue_valid;
    logic                  w_wr_en;
    logic                  w_pop;
    cim_field_struct       w_head;
    logic [CNT_WIDTH-1:0]  r_issued_cnt;

    // Flush forces both handshakes low so nothing completes in the clear cycle
    assign w_host_ready  = !w_full && !bus.flush_i;
    assign w_issue_valid = !w_empty && !bus.flush_i;
    assign w_wr_en       = bus.host_valid_i && w_host_ready && !is_nop(bus.host_inst_i);
    assign w_pop         = w_issue_valid && bus.issue_ready_i;

    cim_inst_fifo #(
        .WIDTH (INST_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (bus.flush_i),
        .wr_en   (w_wr_en),
        .wr_data (bus.host_inst_i),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .count   (w_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issued_cnt <= '0;
        end else if (w_pop) begin
            r_issued_cnt <= r_issued_cnt + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        w_head = '0;
        if (w_issue_valid) w_head = cim_field_struct'(w_rd_data);
    end

    assign bus.host_ready_o  = w_host_ready;
    assign bus.issue_valid_o = w_issue_valid;
    assign bus.issue_op_o    = w_head.op;
    assign bus.issue_s1_o    = w_head.s1;
    assign bus.issue_s2_o    = w_head.s2;
    assign bus.issue_d1_o    = w_head.d1;
    assign bus.count_o       = w_count;
    assign bus.issued_cnt_o  = r_issued_cnt;

endmodule
`default_nettype wire
